minimac2_rxsched: RTL

Receive-slot scheduler for the minimac2 Ethernet MAC, in the `sys_clk` domain between the clock-domain synchroniser and the CSR/software side. It keeps the two receive slots armed, records the order in which they fill, and presents completed frames one at a time, oldest first, through a valid/ack handshake. It also raises an interrupt and counts cycles during which no slot was armed (receive stall).

---
 rtl/minimac2_pkg.sv | 11 +
 rtl/minimac2_rxsched_if.sv | 11 +
 rtl/minimac2_rxslot.sv | 48 ++++
 rtl/minimac2_rxsched.sv | 94 +++++++++
 4 files changed

// File: rtl/minimac2_pkg.sv
// Shared definitions for the minimac2 receive path: slot states and sizing.
package minimac2_pkg;
    localparam int MINIMAC2_CNT_W  = 11;
    localparam int MINIMAC2_NSLOTS = 2;

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_ARMED = 2'd1,
        SLOT_FULL  = 2'd2
    } slot_state_e;
endpackage

// File: rtl/minimac2_rxsched_if.sv
// Completed-frame presentation handshake between the scheduler and the CSR side.
interface minimac2_rxsched_if;
    import minimac2_pkg::*;
    logic                      frm_valid;
    logic                      frm_slot;
    logic [MINIMAC2_CNT_W-1:0] frm_count;
    logic                      frm_ack;

    modport master (output frm_valid, frm_slot, frm_count, input frm_ack);
    modport slave  (input frm_valid, frm_slot, frm_count, output frm_ack);
endinterface

// File: rtl/minimac2_rxslot.sv
// One receive slot: IDLE/ARMED/FULL state machine and the latched byte count.
module minimac2_rxslot
    import minimac2_pkg::*;
#(
    parameter bit AUTO_REARM = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable_i,
    input  logic                      arm_i,
    input  logic                      rx_done_i,
    input  logic [MINIMAC2_CNT_W-1:0] rx_count_i,
    input  logic                      ack_i,
    output logic                      ready_o,
    output logic                      accept_o,
    output logic                      spurious_o,
    output logic [MINIMAC2_CNT_W-1:0] count_o
);
    slot_state_e               state_q, state_d;
    logic [MINIMAC2_CNT_W-1:0] count_q;

    assign accept_o   = rx_done_i && (state_q == SLOT_ARMED);
    assign spurious_o = rx_done_i && (state_q != SLOT_ARMED);
    assign ready_o    = (state_q == SLOT_ARMED);
    assign count_o    = count_q;

    // A fill arriving in the same cycle as a disarm still wins: the frame is already in the slot.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SLOT_IDLE:  if (enable_i && (arm_i || AUTO_REARM)) state_d = SLOT_ARMED;
            SLOT_ARMED: if (rx_done_i) state_d = SLOT_FULL;
                        else if (!enable_i) state_d = SLOT_IDLE;
            SLOT_FULL:  if (ack_i) state_d = (enable_i && AUTO_REARM) ? SLOT_ARMED : SLOT_IDLE;
            default:    state_d = SLOT_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept_o) count_q <= rx_count_i;
        end
    end
endmodule

// File: rtl/minimac2_rxsched.sv
// Receive-slot scheduler: keeps both slots armed, queues fills in arrival order, presents oldest first.
module minimac2_rxsched
    import minimac2_pkg::*;
#(
    parameter bit AUTO_REARM = 1'b1
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       enable,
    input  logic                       arm,
    output logic [MINIMAC2_NSLOTS-1:0] rx_ready,
    input  logic [MINIMAC2_NSLOTS-1:0] rx_done,
    input  logic [MINIMAC2_CNT_W-1:0]  rx_count_0,
    input  logic [MINIMAC2_CNT_W-1:0]  rx_count_1,
    minimac2_rxsched_if.master         frm,
    output logic                       irq,
    output logic                       stall,
    output logic [15:0]                stall_cnt,
    input  logic                       stall_clr,
    output logic                       err
);
    logic [MINIMAC2_NSLOTS-1:0][MINIMAC2_CNT_W-1:0] rx_count_a, slot_cnt;
    logic [MINIMAC2_NSLOTS-1:0] accept, spurious, slot_ack;

    // Order queue: two entries of one-bit slot index, head pointer and occupancy.
    logic [1:0]  q_q, q_d;
    logic        head_q, head_d;
    logic [1:0]  occ_q, occ_d;
    logic        pop;
    logic        stall_q, err_q;
    logic [15:0] stall_cnt_q;

    assign rx_count_a[0] = rx_count_0;
    assign rx_count_a[1] = rx_count_1;

    assign pop = frm.frm_ack && (occ_q != 2'd0);

    for (genvar i = 0; i < MINIMAC2_NSLOTS; i++) begin : g_slot
        assign slot_ack[i] = pop && (q_q[head_q] == 1'(i));
        minimac2_rxslot #(.AUTO_REARM(AUTO_REARM)) u_slot (
            .clk       (sys_clk),
            .rst       (sys_rst),
            .enable_i  (enable),
            .arm_i     (arm),
            .rx_done_i (rx_done[i]),
            .rx_count_i(rx_count_a[i]),
            .ack_i     (slot_ack[i]),
            .ready_o   (rx_ready[i]),
            .accept_o  (accept[i]),
            .spurious_o(spurious[i]),
            .count_o   (slot_cnt[i])
        );
    end

    // Pop first, then append in slot order at head+occupancy, so a push into an empty queue becomes head.
    always_comb begin
        q_d    = q_q;
        head_d = head_q ^ pop;
        occ_d  = occ_q - {1'b0, pop};
        for (int i = 0; i < MINIMAC2_NSLOTS; i++) begin
            if (accept[i]) begin
                q_d[head_d ^ occ_d[0]] = 1'(i);
                occ_d = occ_d + 2'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            q_q         <= '0;
            head_q      <= 1'b0;
            occ_q       <= '0;
            stall_q     <= 1'b0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            q_q     <= q_d;
            head_q  <= head_d;
            occ_q   <= occ_d;
            stall_q <= enable && !(|rx_ready);
            err_q   <= err_q || (|spurious);
            if (stall_clr)                              stall_cnt_q <= '0;
            else if (stall_q && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign frm.frm_valid = (occ_q != 2'd0);
    assign frm.frm_slot  = q_q[head_q];
    assign frm.frm_count = slot_cnt[q_q[head_q]];
    assign irq           = frm.frm_valid;
    assign stall         = stall_q;
    assign stall_cnt     = stall_cnt_q;
    assign err           = err_q;
endmodule
